piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data word width; legal range WIDTH >= 2.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load_valid  input  1  upstream word offer.
REQ-005 load_ready  output  1  block accepts a word this cycle.
REQ-006 load_data  input  WIDTH  parallel word; sampled only on handshake.
REQ-007 shift_en  input  1  bit-advance strobe, shared with the downstream deserializer.
REQ-008 serial_out  output  1  current serial bit, MSB first.
REQ-009 frame  output  1  high while serial_out carries a valid bit.
REQ-010 busy  output  1  high in any non-IDLE state.
REQ-011 done  output  1  one-cycle pulse after the final bit is consumed.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY is reachable only with the REQ-027 macro defined.
REQ-013 load_ready SHALL equal (state == IDLE) and SHALL read 0 while reset is asserted.
REQ-014 Handshake: load_valid & load_ready at a rising edge -> capture load_data into shift_reg, clear bit counter, enter SHIFT.
REQ-015 In IDLE: serial_out = 0, frame = 0; load_valid without load_ready SHALL have no effect.
REQ-016 In SHIFT: serial_out = shift_reg[WIDTH-1]; frame = 1.
REQ-017 Edge with shift_en = 1 in SHIFT: shift_reg shifts left by one with 0 fill; counter increments.
REQ-018 Edge with shift_en = 0: shift_reg, counter, state and serial_out SHALL hold.
REQ-019 Counter width SHALL be $clog2(WIDTH); no wrap occurs because the count ends at WIDTH-1.
REQ-020 Edge with shift_en = 1 and counter == WIDTH-1: go to IDLE, or to PARITY when REQ-027 applies.
REQ-021 done SHALL be registered and high for exactly the one cycle after the edge that consumes the last frame bit (data or parity); state is IDLE in that cycle.
REQ-022 Word spacing: a new handshake SHALL be possible in the done cycle, giving a minimum 1-cycle gap between frames.
REQ-023 Downstream contract: a same-clock deserializer sampling serial_out on shift_en SHALL hold load_data after WIDTH enabled edges.

Reset
REQ-024 Reset asserted SHALL immediately force state = IDLE, shift_reg = 0, counter = 0, serial_out = 0, frame = 0, busy = 0, done = 0.
REQ-025 Reset mid-frame SHALL abort the frame with no done pulse; the partial word is discarded.
REQ-026 After reset deasserts, the first handshake edge SHALL be accepted normally.

Configuration
REQ-027 Macro PISO_SERIALIZER_PARITY_EN defined: even parity of load_data is computed and stored at handshake.
- PARITY state: serial_out = stored parity, frame = 1.
- One shift_en edge -> IDLE plus done; frame is WIDTH+1 bits.
REQ-028 Macro undefined: no parity logic or storage; the frame is WIDTH bits and SHIFT -> IDLE directly.

Structure
REQ-029 Package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY) and the even-parity function.
REQ-030 The block SHALL be a single module with no sub-module; counter, FSM and shift register are local.

Verification
REQ-031 Basic frame, WIDTH = 8, load 8'hA5, shift_en held 1:
- serial_out sequence 1,0,1,0,0,1,0,1; frame high for 8 cycles.
- done pulses once; load_ready returns to 1.
REQ-032 Stall: load 8'hC3, shift_en toggled 1,0,0,1,...:
- serial_out and counter hold on every 0 cycle.
- Bit order is unchanged; done follows the 8th enabled edge.
REQ-033 Loopback: connect to the matching deserializer on the same clock/shift_en and load 8'h5A -> deserializer parallel_out == 8'h5A at the done cycle.
REQ-034 Reset after 3 enabled bits of 8'hFF:
- Outputs go to reset values asynchronously; no done.
- A next load of 8'h01 serializes 0,0,0,0,0,0,0,1.
REQ-035 Back-to-back: load_valid held high with words 8'h11 then 8'h22 -> second handshake occurs in the done cycle of the first; exactly one idle cycle between frames.
REQ-036 With PISO_SERIALIZER_PARITY_EN defined:
- 8'h07 -> 9th bit 1.
- 8'h03 -> 9th bit 0.
- done follows the 9th enabled edge.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// even_parity accepts words up to PARITY_MAX_W bits; callers zero-extend.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

  localparam int PARITY_MAX_W = 64;

  // Bit that makes the total count of ones even; zero padding does not change it.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, MSB first, advanced by a shared shift_en strobe.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
//
// state  | meaning
// IDLE   | waiting for a word; load_ready high
// SHIFT  | data bits on serial_out, one per enabled edge
// PARITY | stored parity bit on serial_out (parity build only)
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  piso_state_e      state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic             done_next;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity_q, parity_next;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      done      <= done_next;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q  <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    parity_next  = parity_q;
`endif
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          shift_next   = load_data;
          bit_cnt_next = '0;
          state_next   = SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
          parity_next  = even_parity(PARITY_MAX_W'(load_data));
`endif
        end
      end
      SHIFT: begin
        if (shift_en) begin
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = IDLE;
            done_next    = 1'b1;
`endif
          end else begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (shift_en) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Reset forces state to IDLE, but the block must not offer readiness while held.
  assign load_ready = (state == IDLE) && !reset;
  assign frame      = (state != IDLE);
  assign busy       = (state != IDLE);

  always_comb begin
    serial_out = 1'b0;
    case (state)
      SHIFT:  serial_out = shift_reg[WIDTH-1];
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: serial_out = parity_q;
`endif
      default: serial_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH = 8); honours PISO_SERIALIZER_PARITY_EN.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int WIDTH = 8;
  localparam int FB = WIDTH + (PAR ? 1 : 0);

  logic             clock = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;
  logic             serial_out;
  logic             frame;
  logic             busy;
  logic             done;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .serial_out (serial_out),
    .frame      (frame),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         period;
    int         edges_np;
    int         edges_p;
  } vec_t;

  vec_t       vecs[8];
  int         checks = 0;
  int         failures = 0;
  logic       sb[$];
  logic       cur_par = 1'b0;
  logic       done_due = 1'b0;
  logic [FB-1:0] des = '0;
  logic [7:0] last_word = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Negedge observer: inputs are stable here, so the upcoming edge's handshake/shift is known.
  task automatic observe();
    logic next_due;
    if (reset) begin
      sb.delete();
      done_due = 1'b0;
      return;
    end
    chk("done", done, done_due);
    if (done) chk("loopback", des[FB-1 -: 8], last_word);
    chk("frame_vs_sb", frame, sb.size() != 0);
    chk("busy_vs_sb", busy, sb.size() != 0);
    if (frame) begin
      if (sb.size() != 0) chk("serial_bit", serial_out, sb[0]);
    end else begin
      chk("idle_serial", serial_out, 1'b0);
    end
    next_due = frame && shift_en && (sb.size() == 1);
    if (frame && shift_en && sb.size() != 0) begin
      des = {des[FB-2:0], serial_out};
      void'(sb.pop_front());
    end
    if (load_valid && load_ready) begin
      for (int i = WIDTH - 1; i >= 0; i--) sb.push_back(load_data[i]);
      if (PAR) sb.push_back(cur_par);
      last_word = load_data;
      des = '0;
    end
    done_due = next_due;
  endtask

  task automatic tick();
    @(negedge clock);
    observe();
    @(posedge clock);
    #1;
  endtask

  task automatic accept_word(input logic [7:0] d, input logic p);
    int n;
    logic ok;
    cur_par = p;
    load_data = d;
    load_valid = 1'b1;
    shift_en = 1'b0;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      ok = load_ready;
      tick();
      n++;
    end
    load_valid = 1'b0;
    chk("accept", ok, 1'b1);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic p, input int period, input int exp_edges);
    int   edges;
    logic got;
    accept_word(d, p);
    edges = 0;
    got = 1'b0;
    while (!got && edges < 200) begin
      shift_en = ((edges % period) == 0);
      tick();
      edges++;
      got = done;
    end
    shift_en = 1'b0;
    chk("frame_edges", edges, exp_edges);
    chk("ready_after", load_ready, 1'b1);
  endtask

  initial begin
    int   edges;
    int   idle_cnt;
    logic started;
    logic got;

    vecs[0] = '{8'hA5, 1'b0, 1, 8, 9};
    vecs[1] = '{8'hC3, 1'b0, 3, 22, 25};
    vecs[2] = '{8'h5A, 1'b0, 1, 8, 9};
    vecs[3] = '{8'h3C, 1'b0, 2, 15, 17};
    vecs[4] = '{8'h07, 1'b1, 1, 8, 9};
    vecs[5] = '{8'h03, 1'b0, 1, 8, 9};
    vecs[6] = '{8'h00, 1'b0, 1, 8, 9};
    vecs[7] = '{8'hFF, 1'b0, 2, 15, 17};

    reset = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    shift_en = 1'b0;
    #3;
    chk("rst_ready", load_ready, 1'b0);
    chk("rst_serial", serial_out, 1'b0);
    chk("rst_frame", frame, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("ready_out_of_reset", load_ready, 1'b1);

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].data, vecs[i].par, vecs[i].period, PAR ? vecs[i].edges_p : vecs[i].edges_np);

    // Abort mid-frame: three bits of 8'hFF, then asynchronous reset between edges.
    accept_word(8'hFF, 1'b0);
    shift_en = 1'b1;
    tick();
    tick();
    tick();
    shift_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("abort_serial", serial_out, 1'b0);
    chk("abort_frame", frame, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready", load_ready, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    run_frame(8'h01, 1'b1, 1, FB);

    // Back-to-back: load_valid held, second handshake lands in the done cycle.
    accept_word(8'h11, 1'b0);
    load_valid = 1'b1;
    load_data = 8'h22;
    shift_en = 1'b1;
    edges = 0;
    idle_cnt = 0;
    started = 1'b0;
    while (!started && edges < 50) begin
      tick();
      edges++;
      if (!frame) idle_cnt++;
      else if (idle_cnt > 0) started = 1'b1;
    end
    load_valid = 1'b0;
    chk("b2b_handshake_edge", edges, FB + 1);
    chk("b2b_idle_cycles", idle_cnt, 1);
    edges = 0;
    got = 1'b0;
    while (!got && edges < 50) begin
      tick();
      edges++;
      got = done;
    end
    shift_en = 1'b0;
    chk("b2b_second_edges", edges, FB);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
